// File: rtl/user_io_pkg.sv
// Shared types and default polynomials for the pad-ring user I/O bridge.
package user_io_pkg;
  typedef enum logic [1:0] {
    MODE_LOOP  = 2'b00,
    MODE_CORE  = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_LFSR  = 2'b11
  } mode_e;

  localparam logic [15:0] MISR_POLY_DEF   = 16'hB400;
  localparam logic [15:0] LFSR_POLY_DEF   = 16'hB400;
  localparam int          SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/user_io_sync.sv
// Multi-stage synchroniser for asynchronous pad inputs; synchronous active-low reset.
module user_io_sync #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  // Stage 0 captures the pad, stage STAGES-1 is the settled output.
  logic [STAGES-1:0][W-1:0] r_stg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_stg <= '0;
    else          r_stg <= {r_stg[STAGES-2:0], i_d};
  end

  assign o_q = r_stg[STAGES-1];
endmodule

// File: rtl/user_io_bridge.sv
// Core-side pad bridge: synchronised inputs, mode-selected registered outputs, input MISR.
// Define USER_IO_LFSR_EN to build the LFSR pattern generator (mode 11).
module user_io_bridge
  import user_io_pkg::*;
#(
  parameter int               N_IN        = 16,
  parameter int               N_OUT       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter int               DIV_W       = 8,
  parameter logic [N_IN-1:0]  MISR_POLY   = N_IN'(MISR_POLY_DEF),
  parameter logic [N_OUT-1:0] LFSR_POLY   = N_OUT'(LFSR_POLY_DEF)
) (
  input  logic             io_clock,
  input  logic             io_reset_n,
  input  logic [N_IN-1:0]  ui_p2c,
  output logic [N_IN-1:0]  core_ui_o,
  input  logic [N_OUT-1:0] core_uo_i,
  output logic [N_OUT-1:0] uo_c2p,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cfg_we_i,
  output logic [1:0]       mode_o,
  input  logic             misr_en_i,
  input  logic             misr_clr_i,
  output logic [N_IN-1:0]  misr_o
);
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [N_IN-1:0]  w_ui;
  mode_e            r_mode, w_cfg_mode;
  logic [DIV_W-1:0] r_div, r_presc;
  logic [N_OUT-1:0] r_cnt, r_uo, w_pat;
  logic [N_IN-1:0]  r_misr;
  logic             w_run, w_tick;

  user_io_sync #(.W(N_IN), .STAGES(SYNC_N)) u_sync (
    .i_clk   (io_clock),
    .i_rst_n (io_reset_n),
    .i_d     (ui_p2c),
    .o_q     (w_ui)
  );

  assign w_run  = (r_mode == MODE_COUNT) || (r_mode == MODE_LFSR);
  assign w_tick = w_run && (r_presc == r_div);

`ifdef USER_IO_LFSR_EN
  logic [N_OUT-1:0] r_lfsr;

  assign w_cfg_mode = mode_e'(mode_i);

  always_ff @(posedge io_clock) begin
    if (!io_reset_n || cfg_we_i) r_lfsr <= N_OUT'(1);
    else if (w_tick)             r_lfsr <= (r_lfsr >> 1) ^ ({N_OUT{r_lfsr[0]}} & LFSR_POLY);
  end

  assign w_pat = (r_mode == MODE_LFSR) ? r_lfsr : r_cnt;
`else
  logic w_unused_lfsr_poly;
  assign w_unused_lfsr_poly = ^LFSR_POLY;

  // Without the generator a request for mode 11 keeps whatever mode is active.
  assign w_cfg_mode = (mode_i == MODE_LFSR) ? r_mode : mode_e'(mode_i);
  assign w_pat      = r_cnt;
`endif

  // A config write restarts the pattern and swallows any coincident step.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      r_mode  <= MODE_LOOP;
      r_div   <= '0;
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (cfg_we_i) begin
      r_mode  <= w_cfg_mode;
      r_div   <= div_i;
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_cnt   <= r_cnt + N_OUT'(1);
    end else if (w_run) begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

  always_ff @(posedge io_clock) begin
    if (!io_reset_n) r_uo <= '0;
    else begin
      case (r_mode)
        MODE_LOOP: r_uo <= N_OUT'(w_ui);
        MODE_CORE: r_uo <= core_uo_i;
        default:   r_uo <= w_pat;
      endcase
    end
  end

  always_ff @(posedge io_clock) begin
    if (!io_reset_n || misr_clr_i) r_misr <= '0;
    else if (misr_en_i)            r_misr <= (r_misr >> 1) ^ ({N_IN{r_misr[0]}} & MISR_POLY) ^ w_ui;
  end

  assign core_ui_o = w_ui;
  assign uo_c2p    = r_uo;
  assign mode_o    = r_mode;
  assign misr_o    = r_misr;
endmodule

// File: tb/tb_user_io_bridge.sv
// Self-checking bench for user_io_bridge: directed bring-up cases plus randomized traffic vs a reference model.
module tb_user_io_bridge;
  localparam logic [15:0] MPOLY = 16'hB400;
  localparam logic [15:0] LPOLY = 16'hB400;
`ifdef USER_IO_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_we, misr_en, misr_clr;
  logic [15:0] ui, core_uo;
  logic [1:0]  mode_i;
  logic [7:0]  div_i;
  logic [15:0] core_ui, uo, misr;
  logic [1:0]  mode_o;
  logic [15:0] core_ui4, misr4;
  logic [3:0]  uo4;
  logic [1:0]  mode4;

  user_io_bridge dut (
    .io_clock(clk), .io_reset_n(rst_n), .ui_p2c(ui), .core_ui_o(core_ui),
    .core_uo_i(core_uo), .uo_c2p(uo), .mode_i(mode_i), .div_i(div_i),
    .cfg_we_i(cfg_we), .mode_o(mode_o), .misr_en_i(misr_en),
    .misr_clr_i(misr_clr), .misr_o(misr)
  );

  user_io_bridge #(.N_OUT(4), .LFSR_POLY(4'hC)) dut4 (
    .io_clock(clk), .io_reset_n(rst_n), .ui_p2c(ui), .core_ui_o(core_ui4),
    .core_uo_i(core_uo[3:0]), .uo_c2p(uo4), .mode_i(mode_i), .div_i(div_i),
    .cfg_we_i(cfg_we), .mode_o(mode4), .misr_en_i(misr_en),
    .misr_clr_i(misr_clr), .misr_o(misr4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after each edge, derived from the mode rules.
  bit          m_ok = 1'b0;
  bit          m_uo_lfsr;
  int          m_mode, m_div, m_presc;
  logic [15:0] m_cnt, m_lfsr, m_misr, m_uo;
  logic [15:0] m_uiq[$];

  always @(posedge clk) begin
    logic [15:0] cui;
    if (!rst_n) begin
      m_ok = 1'b1; m_mode = 0; m_div = 0; m_presc = 0;
      m_cnt = 16'h0; m_lfsr = 16'h1; m_misr = 16'h0; m_uo = 16'h0; m_uo_lfsr = 1'b0;
      m_uiq = '{16'h0, 16'h0};
    end else if (m_ok) begin
      cui = m_uiq[0];
      m_uo_lfsr = (m_mode == 3);
      case (m_mode)
        0: m_uo = cui;
        1: m_uo = core_uo;
        2: m_uo = m_cnt;
        default: m_uo = m_lfsr;
      endcase
      if (misr_clr)     m_misr = 16'h0;
      else if (misr_en) m_misr = (m_misr >> 1) ^ (m_misr[0] ? MPOLY : 16'h0) ^ cui;
      if (cfg_we) begin
        if (mode_i != 2'd3 || LFSR_EN) m_mode = int'(mode_i);
        m_div = int'(div_i); m_presc = 0; m_cnt = 16'h0; m_lfsr = 16'h1;
      end else if (m_mode >= 2) begin
        if (m_presc == m_div) begin
          m_presc = 0;
          m_cnt   = m_cnt + 16'd1;
          m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? LPOLY : 16'h0);
        end else m_presc++;
      end
      void'(m_uiq.pop_front());
      m_uiq.push_back(ui);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("core_ui", core_ui, m_uiq[0]);
      chk("uo", uo, m_uo);
      chk("mode", mode_o, 32'(m_mode));
      chk("misr", misr, m_misr);
      chk("core_ui4", core_ui4, m_uiq[0]);
      chk("mode4", mode4, 32'(m_mode));
      chk("misr4", misr4, m_misr);
      if (!m_uo_lfsr) chk("uo4", uo4, m_uo[3:0]);
    end
  end

  initial begin
    rst_n = 1'b0; ui = '0; core_uo = '0; mode_i = '0; div_i = '0;
    cfg_we = 1'b0; misr_en = 1'b0; misr_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_uo", uo, 0); chk("rst_mode", mode_o, 0);
    chk("rst_misr", misr, 0); chk("rst_core_ui", core_ui, 0);

    // LOOP latency
    rst_n = 1'b1; ui = 16'hA5C3;
    repeat (2) @(negedge clk);
    chk("loop_core_ui_2cyc", core_ui, 16'hA5C3);
    chk("loop_uo_early", uo, 16'h0000);
    @(negedge clk);
    chk("loop_uo_3cyc", uo, 16'hA5C3);

    // CORE mode
    cfg_we = 1'b1; mode_i = 2'b01; core_uo = 16'h1234;
    @(negedge clk); cfg_we = 1'b0;
    chk("core_mode", mode_o, 2'b01);
    @(negedge clk);
    chk("core_uo_lat1", uo, 16'h1234);
    core_uo = 16'h5678; ui = 16'hFFFF;
    @(negedge clk);
    chk("core_uo_follow", uo, 16'h5678);
    repeat (3) @(negedge clk);
    chk("core_ui_ignored", uo, 16'h5678);

    // COUNT, div=3
    cfg_we = 1'b1; mode_i = 2'b10; div_i = 8'd3;
    @(negedge clk); cfg_we = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("count_div3", uo, (k - 1) / 4);
    end

    // COUNT, div=0: 4-bit output wraps after 16 ticks
    cfg_we = 1'b1; div_i = 8'd0;
    @(negedge clk); cfg_we = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) chk("n4_last", uo4, 4'hF);
      if (k == 17) chk("n4_wrap", uo4, 4'h0);
    end

    // MISR
    misr_clr = 1'b1; ui = 16'h0001;
    repeat (2) @(negedge clk);
    chk("misr_clr", misr, 16'h0000);
    misr_clr = 1'b0; misr_en = 1'b1;
    @(negedge clk);
    chk("misr_fold1", misr, 16'h0001);
    @(negedge clk);
    chk("misr_fold2", misr, 16'hB401);
    misr_en = 1'b0;

    // mode 11 request, from COUNT
    cfg_we = 1'b1; mode_i = 2'b11; div_i = 8'd0;
    @(negedge clk); cfg_we = 1'b0;
`ifdef USER_IO_LFSR_EN
    chk("lfsr_mode", mode_o, 2'b11);
    @(negedge clk); chk("lfsr_0", uo, 16'h0001);
    @(negedge clk); chk("lfsr_1", uo, 16'hB400);
    @(negedge clk); chk("lfsr_2", uo, 16'h5A00);
`else
    chk("nolfsr_mode_kept", mode_o, 2'b10);
    @(negedge clk); chk("nolfsr_count_restart", uo, 16'h0000);
`endif

    // Reset mid-COUNT
    cfg_we = 1'b1; mode_i = 2'b10; div_i = 8'd0;
    @(negedge clk); cfg_we = 1'b0;
    repeat (8) @(negedge clk);
    chk("count_at7", uo, 16'h0007);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_uo", uo, 0); chk("midrst_mode", mode_o, 0); chk("midrst_misr", misr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      ui       = 16'($urandom);
      core_uo  = 16'($urandom);
      mode_i   = 2'($urandom_range(0, 3));
      div_i    = 8'($urandom_range(0, 3));
      cfg_we   = ($urandom_range(0, 15) == 0);
      misr_en  = ($urandom_range(0, 1) == 1);
      misr_clr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
